// File: rtl/arbiter_rr_if.sv
// rtl/arbiter_rr_if.sv - request/grant bundle between N bus masters and arbiter_rr
interface arbiter_rr_if #(
    parameter int N = 8
);
    logic [0:N-1]         r;
    logic                 mode;
    logic [0:N-1]         g;
    logic                 valid;
    logic [$clog2(N)-1:0] gid;

    modport master (output r, mode, input g, valid, gid);
    modport slave  (input r, mode, output g, valid, gid);
endinterface

// File: rtl/arbiter_rr.sv
// rtl/arbiter_rr.sv - registered fixed-priority / round-robin arbiter with held grants
// Optional hold-timeout preemption is built in when ARB_TIMEOUT_EN is defined.
module arbiter_rr #(
    parameter int N       = 8,
    parameter int MAXHOLD = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    arbiter_rr_if.slave bus
);
    localparam int IW = $clog2(N);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t         state;
    logic [0:N-1]   g_q;
    logic           valid_q;
    logic [IW-1:0]  gid_q;
    logic [IW-1:0]  ptr;

    logic [0:N-1]   owner_mask;
    logic [0:N-1]   cand;
    logic [0:N-1]   win_oh;
    logic [IW-1:0]  win;
    logic [IW-1:0]  ptr_next;
    logic           win_any;
    logic           owner_req;
    logic           preempt;
    int             scan_idx;

`ifdef ARB_TIMEOUT_EN
    localparam int HW = $clog2(MAXHOLD + 1);
    logic [HW-1:0]  hold_cnt;

    assign preempt = (state == BUSY) && owner_req && (hold_cnt == HW'(MAXHOLD))
                     && (|(bus.r & ~owner_mask));
`else
    logic unused_maxhold;

    assign unused_maxhold = (MAXHOLD > 0);
    assign preempt        = 1'b0;
`endif

    always_comb begin
        owner_mask        = '0;
        owner_mask[gid_q] = 1'b1;
    end

    assign owner_req = |(bus.r & owner_mask);
    assign cand      = preempt ? (bus.r & ~owner_mask) : bus.r;

    // Fixed mode is simply a scan that always starts at index 0.
    always_comb begin
        win      = '0;
        win_any  = 1'b0;
        scan_idx = 0;
        for (int k = 0; k < N; k++) begin
            scan_idx = (bus.mode ? int'(ptr) : 0) + k;
            if (scan_idx >= N) scan_idx = scan_idx - N;
            if (!win_any && cand[scan_idx]) begin
                win_any = 1'b1;
                win     = IW'(scan_idx);
            end
        end
    end

    always_comb begin
        win_oh      = '0;
        win_oh[win] = 1'b1;
    end

    assign ptr_next = (win == IW'(N - 1)) ? '0 : win + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            g_q     <= '0;
            valid_q <= 1'b0;
            gid_q   <= '0;
            ptr     <= '0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (win_any) begin
                        state   <= BUSY;
                        g_q     <= win_oh;
                        valid_q <= 1'b1;
                        gid_q   <= win;
                        ptr     <= ptr_next;
`ifdef ARB_TIMEOUT_EN
                        hold_cnt <= HW'(1);
`endif
                    end
                end
                BUSY: begin
                    if (owner_req && !preempt) begin
`ifdef ARB_TIMEOUT_EN
                        if (hold_cnt != HW'(MAXHOLD)) hold_cnt <= hold_cnt + 1'b1;
`endif
                    end else if (win_any) begin
                        // Same-edge handoff: no idle bubble between owners.
                        g_q     <= win_oh;
                        valid_q <= 1'b1;
                        gid_q   <= win;
                        ptr     <= ptr_next;
`ifdef ARB_TIMEOUT_EN
                        hold_cnt <= HW'(1);
`endif
                    end else begin
                        state   <= IDLE;
                        g_q     <= '0;
                        valid_q <= 1'b0;
                        gid_q   <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.g     = g_q;
    assign bus.valid = valid_q;
    assign bus.gid   = gid_q;
endmodule

// File: tb/tb_arbiter_rr.sv
// tb/tb_arbiter_rr.sv - scoreboard bench for arbiter_rr (N = 8, MAXHOLD = 4)
module tb_arbiter_rr;
    logic clk;
    logic rst_n;

    arbiter_rr_if #(.N(8)) bus ();

    arbiter_rr #(.N(8), .MAXHOLD(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] v;
        string       name;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [11:0] got;
    int          total = 0;
    int          bad   = 0;

    function automatic logic [11:0] mk(input logic [0:7] eg, input logic [2:0] egid);
        return {eg, |eg, egid};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        bus.r    = 8'b1111_1111;
        bus.mode = 1'b0;
        repeat (2) tick();
        got = {bus.g, bus.valid, bus.gid};
        total++;
        if (got !== 12'h000) begin
            bad++;
            $display("FAIL reset_held got=%h exp=%h", got, 12'h000);
        end
        rst_n    = 1'b1;
        bus.mode = 1'b1;
        sb.push_back('{mk(8'b1000_0000, 3'd0), "reset_first_grant"});
        tick();
        e = sb.pop_front();
        got = {bus.g, bus.valid, bus.gid};
        total++;
        if (got !== e.v) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", e.name, got, e.v);
        end
    endtask

    task automatic test_fixed_handoff();
        bus.r = 8'b0000_0000;
        tick();
        bus.mode = 1'b0;
        for (int c = 0; c < 5; c++) begin
            case (c)
                0: begin bus.r = 8'b0110_0000; sb.push_back('{mk(8'b0100_0000, 3'd1), "fixed_first"}); end
                1: begin bus.r = 8'b0110_0000; sb.push_back('{mk(8'b0100_0000, 3'd1), "fixed_hold"}); end
                2: begin bus.r = 8'b0010_0000; sb.push_back('{mk(8'b0010_0000, 3'd2), "fixed_handoff"}); end
                3: begin bus.r = 8'b0010_0000; sb.push_back('{mk(8'b0010_0000, 3'd2), "fixed_hold2"}); end
                default: begin bus.r = 8'b0000_0000; sb.push_back('{mk(8'b0000_0000, 3'd0), "fixed_idle"}); end
            endcase
            // Grant must not react to r before the edge.
            if (c == 2) begin
                #1;
                got = {bus.g, bus.valid, bus.gid};
                total++;
                if (got !== mk(8'b0100_0000, 3'd1)) begin
                    bad++;
                    $display("FAIL fixed_no_comb_path got=%h exp=%h", got, mk(8'b0100_0000, 3'd1));
                end
            end
            tick();
            e = sb.pop_front();
            got = {bus.g, bus.valid, bus.gid};
            total++;
            if (got !== e.v) begin
                bad++;
                $display("FAIL %s got=%h exp=%h", e.name, got, e.v);
            end
        end
    endtask

    task automatic test_rr_fairness();
        logic [0:7] rv;
        logic [0:7] eg;
        rst_n = 1'b0;
        #2;
        rst_n    = 1'b1;
        bus.mode = 1'b1;
        bus.r    = 8'b1111_1111;
        sb.push_back('{mk(8'b1000_0000, 3'd0), "rr_gid0"});
        tick();
        e = sb.pop_front();
        got = {bus.g, bus.valid, bus.gid};
        total++;
        if (got !== e.v) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", e.name, got, e.v);
        end
        for (int k = 0; k < 8; k++) begin
            rv    = 8'b1111_1111;
            rv[k] = 1'b0;
            bus.r = rv;
            eg    = '0;
            eg[(k + 1) % 8] = 1'b1;
            sb.push_back('{mk(eg, 3'((k + 1) % 8)), $sformatf("rr_step%0d", k)});
            tick();
            e = sb.pop_front();
            got = {bus.g, bus.valid, bus.gid};
            total++;
            if (got !== e.v) begin
                bad++;
                $display("FAIL %s got=%h exp=%h", e.name, got, e.v);
            end
        end
    endtask

    task automatic test_async_reset();
        rst_n = 1'b0;
        #2;
        rst_n    = 1'b1;
        bus.mode = 1'b0;
        bus.r    = 8'b0001_0000;
        sb.push_back('{mk(8'b0001_0000, 3'd3), "async_owner3"});
        tick();
        e = sb.pop_front();
        got = {bus.g, bus.valid, bus.gid};
        total++;
        if (got !== e.v) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", e.name, got, e.v);
        end
        #2;
        rst_n = 1'b0;
        #1;
        got = {bus.g, bus.valid, bus.gid};
        total++;
        if (got !== 12'h000) begin
            bad++;
            $display("FAIL async_clear got=%h exp=%h", got, 12'h000);
        end
        bus.mode = 1'b1;
        bus.r    = 8'b1111_1111;
        rst_n    = 1'b1;
        sb.push_back('{mk(8'b1000_0000, 3'd0), "async_ptr_restart"});
        tick();
        e = sb.pop_front();
        got = {bus.g, bus.valid, bus.gid};
        total++;
        if (got !== e.v) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", e.name, got, e.v);
        end
    endtask

    task automatic test_timeout();
        logic first;
        rst_n = 1'b0;
        #2;
        rst_n    = 1'b1;
        bus.mode = 1'b1;
        bus.r    = 8'b1100_0000;
        for (int c = 0; c < 12; c++) begin
`ifdef ARB_TIMEOUT_EN
            first = ((c / 4) % 2) == 0;
`else
            first = 1'b1;
`endif
            if (first) sb.push_back('{mk(8'b1000_0000, 3'd0), $sformatf("timeout_c%0d", c)});
            else       sb.push_back('{mk(8'b0100_0000, 3'd1), $sformatf("timeout_c%0d", c)});
            tick();
            e = sb.pop_front();
            got = {bus.g, bus.valid, bus.gid};
            total++;
            if (got !== e.v) begin
                bad++;
                $display("FAIL %s got=%h exp=%h", e.name, got, e.v);
            end
        end
    endtask

    task automatic test_mode_switch();
        rst_n = 1'b0;
        #2;
        rst_n    = 1'b1;
        bus.mode = 1'b1;
        for (int c = 0; c < 4; c++) begin
            case (c)
                0: begin bus.r = 8'b0000_0100; sb.push_back('{mk(8'b0000_0100, 3'd5), "mode_owner5"}); end
                1: begin bus.mode = 1'b0; bus.r = 8'b1000_0100; sb.push_back('{mk(8'b0000_0100, 3'd5), "mode_no_preempt"}); end
                2: begin bus.r = 8'b1000_0100; sb.push_back('{mk(8'b0000_0100, 3'd5), "mode_still_held"}); end
                default: begin bus.r = 8'b1000_0000; sb.push_back('{mk(8'b1000_0000, 3'd0), "mode_fixed_win"}); end
            endcase
            tick();
            e = sb.pop_front();
            got = {bus.g, bus.valid, bus.gid};
            total++;
            if (got !== e.v) begin
                bad++;
                $display("FAIL %s got=%h exp=%h", e.name, got, e.v);
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        bus.r    = '0;
        bus.mode = 1'b0;
        test_reset();
        test_fixed_handoff();
        test_rr_fairness();
        test_async_reset();
        test_timeout();
        test_mode_switch();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
